// File: rtl/rr_mux_pkg.sv
// Shared constants and the rotate-priority one-hot grant helper for rr_mux_arb.
package rr_mux_pkg;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 32;
  // Upper bound on channel count supported by the grant helper.
  localparam int MAX_CH     = 32;
  localparam int MAX_SEL_W  = 5;

  // One-hot grant: first set bit of req at or after ptr, wrapping mod n.
  function automatic logic [MAX_CH-1:0] rr_onehot(input logic [MAX_CH-1:0] req,
                                                  input int unsigned n,
                                                  input int unsigned ptr);
    logic [MAX_CH-1:0]    gnt;
    logic [MAX_SEL_W-1:0] idx;
    logic                 found;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_CH; k++) begin
      idx = MAX_SEL_W'((ptr + k) % n);
      if (k < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction
endpackage

// File: rtl/rr_mux_grant.sv
// Combinational rotate-priority encoder: grant index and found flag from req and ptr.
module rr_mux_grant
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = $clog2(DEF_NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  gnt_idx,
  output logic              found
);
  logic [MAX_CH-1:0] gnt_oh;

  always_comb begin
    gnt_oh  = rr_onehot(MAX_CH'(req), NUM_CH, 32'(ptr));
    gnt_idx = '0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (gnt_oh[i]) gnt_idx = SEL_W'(i);
    end
    found = |gnt_oh;
  end
endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin arbitrating mux: NUM_CH valid/ready sources onto one registered output.
// Optional RR_MUX_FORCE_EN adds force_en/force_sel to bypass arbitration.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int WIDTH  = DEF_WIDTH,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        out_sel
`ifdef RR_MUX_FORCE_EN
  ,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel
`endif
);
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] rr_idx, g;
  logic             rr_found, found, forced;
  logic             load, xfer;
  logic [WIDTH-1:0] sel_data;

  rr_mux_grant #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_grant (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (rr_idx),
    .found   (rr_found)
  );

  always_comb begin
    g      = rr_idx;
    found  = rr_found;
    forced = 1'b0;
`ifdef RR_MUX_FORCE_EN
    if (force_en) begin
      // Out-of-range force_sel matches no channel, so there is no grant.
      forced = 1'b1;
      g      = force_sel;
      found  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (force_sel == SEL_W'(i)) found = in_valid[i];
      end
    end
`endif
  end

  assign load = !out_valid_q || out_ready;
  assign xfer = load && found && !rst;

  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (g == SEL_W'(i)) begin
        in_ready[i] = xfer;
        sel_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) out_valid_d = found;
    if (xfer) begin
      out_data_d = sel_data;
      out_sel_d  = g;
      // Explicit wrap keeps non-power-of-2 channel counts correct.
      if (!forced) ptr_d = (g == SEL_W'(NUM_CH-1)) ? '0 : g + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
endmodule
